// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the
// serial BCD subtractor.
package bcd_pkg;

  localparam int DIGIT_W   = 4;
  localparam int DIGIT_MAX = 9;
  localparam int BCD_RADIX = 10;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of a - b - bi.
// Negative results are corrected by adding the radix.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bi,
  output logic [DIGIT_W-1:0] d,
  output logic               bo,
  output logic               invalid
);

  // a - b - bi lies in -16..15, so 5 signed bits are exact
  logic [DIGIT_W:0] raw;

  assign raw = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bi};
  assign bo  = raw[DIGIT_W];
  assign d   = bo ? raw[DIGIT_W-1:0] + DIGIT_W'(BCD_RADIX)
                  : raw[DIGIT_W-1:0];

  assign invalid = (a > DIGIT_W'(DIGIT_MAX)) ||
                   (b > DIGIT_W'(DIGIT_MAX));

endmodule

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor: diff = x - y - bin,
// one digit per clock, LSD first, ten's complement when negative.
module bcd_subtractor_serial
  import bcd_pkg::*;
#(
  parameter int M = 3,
  parameter int N = 4 * M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         err
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;

  state_t state_q;
  state_t state_d;

  logic [N-1:0]  xs_q;
  logic [N-1:0]  ys_q;
  logic          brw_q;
  logic          err_acc_q;
  logic [CW-1:0] cnt_q;

  logic [N-1:0]  diff_q;
  logic          bout_q;
  logic          err_q;
  logic          done_q;

  logic [DIGIT_W-1:0] dig;
  logic               dig_bo;
  logic               dig_inv;
  logic [N-1:0]       diff_next;

  logic accept;
  logic step;
  logic last;

  assign accept = (state_q == IDLE) && start;
  assign step   = (state_q == RUN);
  assign last   = (cnt_q == CW'(M - 1));

  bcd_digit_sub u_digit (
    .a       (xs_q[DIGIT_W-1:0]),
    .b       (ys_q[DIGIT_W-1:0]),
    .bi      (brw_q),
    .d       (dig),
    .bo      (dig_bo),
    .invalid (dig_inv)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xs_q      <= '0;
      ys_q      <= '0;
      brw_q     <= 1'b0;
      err_acc_q <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      xs_q      <= x;
      ys_q      <= y;
      brw_q     <= bin;
      err_acc_q <= 1'b0;
      cnt_q     <= '0;
    end else if (step) begin
      xs_q      <= xs_q >> DIGIT_W;
      ys_q      <= ys_q >> DIGIT_W;
      brw_q     <= dig_bo;
      err_acc_q <= err_acc_q | dig_inv;
      if (!last) cnt_q <= cnt_q + 1'b1;
    end
  end

  // New digits enter at the MSD end; after M steps digit 0 sits at the bottom
  generate
    if (M == 1) begin : g_one
      assign diff_next = dig;
    end else begin : g_multi
      logic [N-DIGIT_W-1:0] res_q;

      assign diff_next = {dig, res_q};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_q <= '0;
        end else if (step) begin
          res_q <= diff_next[N-1:DIGIT_W];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q <= '0;
      bout_q <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (step && last) begin
        diff_q <= diff_next;
        bout_q <= dig_bo;
        err_q  <= err_acc_q | dig_inv;
        done_q <= 1'b1;
      end
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign err  = err_q;

endmodule
